// File: rtl/fighter_palette_pkg.sv
// Shared types and constants for the fighter palette controller.
// Holds the default colour table loaded on reset.
package fighter_palette_pkg;

  typedef enum logic [1:0] {
    FL_IDLE,
    FL_ON,
    FL_OFF
  } flash_state_e;

  localparam logic [11:0] KEY_COLOR_DEF   = 12'hF0F;
  localparam logic [11:0] FLASH_COLOR_DEF = 12'hFFF;

  localparam int DEF_PAL_N = 16;
  localparam logic [11:0] DEFAULT_PALETTE [DEF_PAL_N] = '{
    12'hF0F, 12'hB66, 12'h101, 12'hA18, 12'h902, 12'h105, 12'hFCA, 12'hE1D,
    12'h628, 12'hD97, 12'h954, 12'h915, 12'hC1B, 12'h733, 12'hD79, 12'h411
  };

  // Entries past the end of the default table come up black.
  function automatic logic [11:0] default_entry(input int idx);
    if (idx < DEF_PAL_N) return DEFAULT_PALETTE[idx];
    return 12'h000;
  endfunction

endpackage

// File: rtl/palette_flash_fsm.sv
// Hit-flash sequencer: alternates ON/OFF once per video frame for a fixed
// number of frames, restartable at any time.
//   state    | meaning
//   FL_IDLE  | no flash in progress
//   FL_ON    | flash colour forced on opaque pixels this frame
//   FL_OFF   | flash in progress, normal colours this frame
module palette_flash_fsm
  import fighter_palette_pkg::*;
#(
  parameter int FLASH_FRAMES = 8
) (
  input  logic Clk,
  input  logic Reset,
  input  logic frame_tick,
  input  logic flash_start,
  output logic flash_on,
  output logic flash_active
);

  localparam int FC_W = $clog2(FLASH_FRAMES + 1);

  flash_state_e    state_q, state_d;
  logic [FC_W-1:0] fc_q, fc_d;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= FL_IDLE;
      fc_q    <= '0;
    end else begin
      state_q <= state_d;
      fc_q    <= fc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    fc_d    = fc_q;
    if (flash_start) begin
      // A restart wins over a coincident frame tick.
      state_d = FL_ON;
      fc_d    = FC_W'(FLASH_FRAMES);
    end else if (frame_tick && (state_q != FL_IDLE)) begin
      fc_d = fc_q - FC_W'(1);
      if (fc_d == '0) state_d = FL_IDLE;
      else            state_d = (state_q == FL_ON) ? FL_OFF : FL_ON;
    end
  end

  assign flash_on     = (state_q == FL_ON);
  assign flash_active = (state_q != FL_IDLE);

endmodule

// File: rtl/fighter_palette_ctrl.sv
// Multi-bank runtime palette with a 2-stage lookup pipeline, transparency
// detection, per-pixel dimming and hit-flash override.
module fighter_palette_ctrl
  import fighter_palette_pkg::*;
#(
  parameter int IDX_W        = 4,
  parameter int CH_W         = 4,
  parameter int BANKS        = 2,
  parameter int FLASH_FRAMES = 8,
  parameter logic [3*CH_W-1:0] FLASH_COLOR = {3*CH_W{1'b1}},
  parameter logic [3*CH_W-1:0] KEY_COLOR   = {{CH_W{1'b1}}, {CH_W{1'b0}}, {CH_W{1'b1}}},
  localparam int BK_W = (BANKS > 1) ? $clog2(BANKS) : 1
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              rd_valid,
  input  logic [BK_W-1:0]   rd_bank,
  input  logic [IDX_W-1:0]  rd_index,
  input  logic [1:0]        dim,
  input  logic              wr_en,
  input  logic [BK_W-1:0]   wr_bank,
  input  logic [IDX_W-1:0]  wr_index,
  input  logic [3*CH_W-1:0] wr_color,
  input  logic              frame_tick,
  input  logic              flash_start,
  output logic              out_valid,
  output logic [CH_W-1:0]   red,
  output logic [CH_W-1:0]   green,
  output logic [CH_W-1:0]   blue,
  output logic              transparent,
  output logic              flash_active
);

  localparam int DEPTH = 2 ** IDX_W;
  localparam int ENT_W = 3 * CH_W;
  localparam int N_ENT = BANKS * DEPTH;

  logic [ENT_W-1:0] pal_q [N_ENT];
  logic [ENT_W-1:0] pal_d [N_ENT];

  logic [BK_W+IDX_W-1:0] wr_addr, rd_addr;
  logic [ENT_W-1:0]      rd_entry;

  logic             s1_valid_q, s1_valid_d;
  logic [ENT_W-1:0] s1_entry_q, s1_entry_d;
  logic [1:0]       s1_dim_q, s1_dim_d;

  logic             s2_valid_q, s2_valid_d;
  logic [ENT_W-1:0] s2_pix_q, s2_pix_d;
  logic             s2_tr_q, s2_tr_d;

  logic flash_on;

  assign wr_addr = {wr_bank, wr_index};
  assign rd_addr = {rd_bank, rd_index};

  always_comb begin
    pal_d = pal_q;
    if (wr_en && (32'(wr_bank) < BANKS)) pal_d[wr_addr] = wr_color;
  end

  // Reads see the pre-write array, so a same-cycle write/read returns the old value.
  always_comb begin
    rd_entry = '0;
    if (32'(rd_bank) < BANKS) rd_entry = pal_q[rd_addr];
  end

  always_comb begin
    s1_valid_d = rd_valid;
    s1_entry_d = rd_entry;
    s1_dim_d   = dim;
  end

  always_comb begin
    s2_valid_d = s1_valid_q;
    s2_tr_d    = (s1_entry_q == KEY_COLOR);
    if (s2_tr_d)       s2_pix_d = s1_entry_q;
    else if (flash_on) s2_pix_d = FLASH_COLOR;
    else begin
      s2_pix_d = {s1_entry_q[3*CH_W-1:2*CH_W] >> s1_dim_q,
                  s1_entry_q[2*CH_W-1:CH_W]   >> s1_dim_q,
                  s1_entry_q[CH_W-1:0]        >> s1_dim_q};
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < N_ENT; i++) pal_q[i] <= ENT_W'(default_entry(i % DEPTH));
      s1_valid_q <= 1'b0;
      s1_entry_q <= '0;
      s1_dim_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_pix_q   <= '0;
      s2_tr_q    <= 1'b0;
    end else begin
      pal_q      <= pal_d;
      s1_valid_q <= s1_valid_d;
      s1_entry_q <= s1_entry_d;
      s1_dim_q   <= s1_dim_d;
      s2_valid_q <= s2_valid_d;
      s2_pix_q   <= s2_pix_d;
      s2_tr_q    <= s2_tr_d;
    end
  end

  palette_flash_fsm #(
    .FLASH_FRAMES(FLASH_FRAMES)
  ) u_flash (
    .Clk         (Clk),
    .Reset       (Reset),
    .frame_tick  (frame_tick),
    .flash_start (flash_start),
    .flash_on    (flash_on),
    .flash_active(flash_active)
  );

  assign out_valid   = s2_valid_q;
  assign red         = s2_pix_q[3*CH_W-1:2*CH_W];
  assign green       = s2_pix_q[2*CH_W-1:CH_W];
  assign blue        = s2_pix_q[CH_W-1:0];
  assign transparent = s2_tr_q;

endmodule

// File: tb/tb_fighter_palette_ctrl.sv
// Scoreboard bench for fighter_palette_ctrl: lookups push expected pixels,
// the output monitor pops and compares them on the cycle they are due.
module tb_fighter_palette_ctrl;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        rd_valid;
  logic [0:0]  rd_bank;
  logic [3:0]  rd_index;
  logic [1:0]  dim;
  logic        wr_en;
  logic [0:0]  wr_bank;
  logic [3:0]  wr_index;
  logic [11:0] wr_color;
  logic        frame_tick;
  logic        flash_start;
  logic        out_valid;
  logic [3:0]  red, green, blue;
  logic        transparent;
  logic        flash_active;

  fighter_palette_ctrl dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .rd_valid    (rd_valid),
    .rd_bank     (rd_bank),
    .rd_index    (rd_index),
    .dim         (dim),
    .wr_en       (wr_en),
    .wr_bank     (wr_bank),
    .wr_index    (wr_index),
    .wr_color    (wr_color),
    .frame_tick  (frame_tick),
    .flash_start (flash_start),
    .out_valid   (out_valid),
    .red         (red),
    .green       (green),
    .blue        (blue),
    .transparent (transparent),
    .flash_active(flash_active)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [11:0] rgb;
    logic        tr;
    int          due;
    string       tag;
  } exp_t;

  exp_t sbq[$];
  int   n_total = 0;
  int   n_bad   = 0;
  int   cyc     = 0;

  localparam logic [11:0] TB_DEF [16] = '{
    12'hF0F, 12'hB66, 12'h101, 12'hA18, 12'h902, 12'h105, 12'hFCA, 12'hE1D,
    12'h628, 12'hD97, 12'h954, 12'h915, 12'hC1B, 12'h733, 12'hD79, 12'h411
  };
  logic [11:0] mdl [2][16];

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [12:0] model_pix(input logic [11:0] e, input logic [1:0] d,
                                            input logic fl);
    logic [3:0] r, g, b;
    if (e == 12'hF0F) return {1'b1, e};
    if (fl) return {1'b0, 12'hFFF};
    r = e[11:8] >> d;
    g = e[7:4] >> d;
    b = e[3:0] >> d;
    return {1'b0, r, g, b};
  endfunction

  task automatic mdl_reset();
    for (int bk = 0; bk < 2; bk++)
      for (int ix = 0; ix < 16; ix++) mdl[bk][ix] = TB_DEF[ix];
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
    rd_valid    = 1'b0;
    wr_en       = 1'b0;
    frame_tick  = 1'b0;
    flash_start = 1'b0;
    dim         = 2'd0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic issue(input logic [0:0] b, input logic [3:0] ix, input logic [1:0] d,
                       input logic [11:0] exp_rgb, input logic exp_tr, input string tag);
    exp_t e;
    rd_valid = 1'b1;
    rd_bank  = b;
    rd_index = ix;
    dim      = d;
    e.rgb = exp_rgb;
    e.tr  = exp_tr;
    e.due = cyc + 2;
    e.tag = tag;
    sbq.push_back(e);
  endtask

  task automatic issue_m(input logic [0:0] b, input logic [3:0] ix, input logic [1:0] d,
                         input string tag);
    logic [12:0] p;
    p = model_pix(mdl[b][ix], d, 1'b0);
    issue(b, ix, d, p[11:0], p[12], tag);
  endtask

  task automatic drv_write(input logic [0:0] b, input logic [3:0] ix, input logic [11:0] c);
    wr_en    = 1'b1;
    wr_bank  = b;
    wr_index = ix;
    wr_color = c;
    mdl[b][ix] = c;
  endtask

  always @(negedge Clk) begin
    exp_t e;
    if (sbq.size() > 0 && sbq[0].due == cyc) begin
      e = sbq.pop_front();
      chk({e.tag, "_vld"}, 32'(out_valid), 32'd1);
      chk({e.tag, "_rgb"}, 32'({red, green, blue}), 32'(e.rgb));
      chk({e.tag, "_tr"}, 32'(transparent), 32'(e.tr));
    end else if (out_valid === 1'b1) begin
      chk("unexpected_vld", 32'(out_valid), 32'd0);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    Reset = 1'b1;
    rd_valid = 1'b0; rd_bank = '0; rd_index = '0; dim = '0;
    wr_en = 1'b0; wr_bank = '0; wr_index = '0; wr_color = '0;
    frame_tick = 1'b0; flash_start = 1'b0;
    mdl_reset();
    idle(3);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_rgb", 32'({red, green, blue}), 32'd0);
    chk("rst_tr", 32'(transparent), 32'd0);
    chk("rst_flash_act", 32'(flash_active), 32'd0);
    Reset = 1'b0;
    step();

    issue(0, 1, 0, 12'hB66, 1'b0, "rd_b66");  step();
    issue(0, 0, 0, 12'hF0F, 1'b1, "rd_key");  step();
    issue(1, 6, 0, 12'hFCA, 1'b0, "wr_same_old");
    drv_write(1, 6, 12'h3C5);                 step();
    issue(1, 6, 0, 12'h3C5, 1'b0, "wr_new");  step();
    issue(0, 6, 0, 12'hFCA, 1'b0, "b0_keep"); step();
    issue(0, 6, 2, 12'h332, 1'b0, "dim2");    step();
    issue(0, 0, 2, 12'hF0F, 1'b1, "dim2_key"); step();
    idle(4);

    flash_start = 1'b1; step();
    chk("flash_act_start", 32'(flash_active), 32'd1);
    for (int k = 0; k < 8; k++) begin
      issue(0, 1, 0, (k % 2 == 0) ? 12'hFFF : 12'hB66, 1'b0, "flash_px"); step();
      issue(0, 0, 0, 12'hF0F, 1'b1, "flash_key"); step();
      idle(3);
      frame_tick = 1'b1; step();
      chk("flash_act_tick", 32'(flash_active), (k < 7) ? 32'd1 : 32'd0);
    end
    issue(0, 1, 0, 12'hB66, 1'b0, "post_flash"); step();
    idle(3);
    frame_tick = 1'b1; step();
    chk("idle_tick", 32'(flash_active), 32'd0);

    flash_start = 1'b1; step();
    for (int t = 0; t < 6; t++) begin
      frame_tick = 1'b1; step();
      step();
    end
    frame_tick = 1'b1; flash_start = 1'b1; step();
    issue(0, 1, 0, 12'hFFF, 1'b0, "restart_on"); step();
    idle(3);
    for (int t = 1; t <= 8; t++) begin
      frame_tick = 1'b1; step();
      chk("restart_cnt", 32'(flash_active), (t < 8) ? 32'd1 : 32'd0);
      if (t == 1) begin
        issue(0, 1, 0, 12'hB66, 1'b0, "restart_off"); step();
        idle(3);
      end
    end
    idle(2);

    for (int i = 0; i < 60; i++) begin
      logic [0:0] rb, wb;
      logic [3:0] ri, wi;
      rb = 1'($urandom_range(0, 1));
      ri = 4'($urandom_range(0, 15));
      wb = 1'($urandom_range(0, 1));
      wi = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) != 0) issue_m(rb, ri, 2'($urandom_range(0, 3)), "rand_rd");
      if ($urandom_range(0, 1) != 0) drv_write(wb, wi, 12'($urandom_range(0, 4095)));
      step();
    end
    idle(4);

    mdl_reset();
    drv_write(0, 1, 12'h123); step();
    drv_write(1, 6, 12'h3C5); step();
    flash_start = 1'b1; step();
    issue(0, 1, 0, 12'hFFF, 1'b0, "dropped_a"); step();
    issue(0, 1, 0, 12'hFFF, 1'b0, "dropped_b");
    Reset = 1'b1;
    sbq.delete();
    step();
    chk("rst_mid_flash_act", 32'(flash_active), 32'd0);
    chk("rst_mid_out_valid", 32'(out_valid), 32'd0);
    Reset = 1'b0;
    mdl_reset();
    step();
    issue(0, 1, 0, 12'hB66, 1'b0, "revert_b0"); step();
    issue(1, 6, 0, 12'hFCA, 1'b0, "revert_b1"); step();
    idle(5);

    chk("sb_drain", 32'(sbq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
